// File: rtl/ooo_ckpt_pkg.sv
// Shared constants and age helper for the speculative checkpoint store.
`default_nettype none

package ooo_ckpt_pkg;

  localparam int CKPT_DEPTH_DEFAULT   = 8;
  localparam int CKPT_ALLOC_W_DEFAULT = 2;

  typedef int unsigned ckpt_idx_t;

  // Distance of idx from tail around a power-of-two ring.
  function automatic ckpt_idx_t ckpt_age(ckpt_idx_t idx, ckpt_idx_t tail, ckpt_idx_t depth);
    return (idx - tail) & (depth - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ckpt_age_match.sv
// Combinational tag search returning the oldest valid in-window match.
`default_nettype none

module ckpt_age_match
  import ooo_ckpt_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 5,
  parameter int DEPTH      = CKPT_DEPTH_DEFAULT
) (
  input  logic [DEPTH-1:0]            i_valid,
  input  logic [DEPTH*ROB_WIDTH-1:0]  i_tags,
  input  logic [DEPTH*DATA_WIDTH-1:0] i_data,
  input  logic [$clog2(DEPTH)-1:0]    i_tail,
  input  logic [$clog2(DEPTH):0]      i_count,
  input  logic [ROB_WIDTH-1:0]        i_tag,
  output logic                        o_hit,
  output logic [$clog2(DEPTH)-1:0]    o_idx,
  output logic [$clog2(DEPTH)-1:0]    o_age,
  output logic [DATA_WIDTH-1:0]       o_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] match;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = i_valid[i] && (i_tags[i*ROB_WIDTH +: ROB_WIDTH] == i_tag);
    end
  end

  // Scan youngest to oldest so the last hit written is the oldest one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx   = '0;
    o_hit = 1'b0;
    o_idx = '0;
    o_age = '0;
    for (int a = DEPTH - 1; a >= 0; a--) begin
      idx = i_tail + PTR_W'(a);
      if (match[idx] && (CNT_W'(a) < i_count)) begin
        o_hit = 1'b1;
        o_idx = idx;
        o_age = PTR_W'(a);
      end
    end
  end

  assign o_data = i_data[o_idx*DATA_WIDTH +: DATA_WIDTH];

endmodule

`default_nettype wire

// File: rtl/checkpoint_queue_mw.sv
// Multi-lane circular checkpoint store: in-order alloc/commit, oldest-match restore, flush.
`default_nettype none

module checkpoint_queue_mw
  import ooo_ckpt_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 5,
  parameter int DEPTH      = CKPT_DEPTH_DEFAULT,
  parameter int ALLOC_W    = CKPT_ALLOC_W_DEFAULT,
  parameter int COMMIT_W   = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [ALLOC_W-1:0]            i_alloc,
  input  logic [ALLOC_W*ROB_WIDTH-1:0]  i_alloc_tag,
  input  logic [ALLOC_W*DATA_WIDTH-1:0] i_alloc_data,
  output logic                          o_alloc_ready,
  output logic [$clog2(DEPTH):0]        o_free_count,
  input  logic [COMMIT_W-1:0]           i_commit,
  input  logic [COMMIT_W*ROB_WIDTH-1:0] i_commit_tag,
  input  logic                          i_restore,
  input  logic [ROB_WIDTH-1:0]          i_restore_tag,
  output logic                          o_restore_hit,
  output logic [DATA_WIDTH-1:0]         o_restore_data,
  input  logic                          i_flush,
  output logic                          o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ROB_WIDTH-1:0]  rob_tag;
  } checkpoint_t;

  logic [CNT_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  checkpoint_t      ckpt_q [DEPTH];

  logic [CNT_W-1:0] count, free_cnt, n_alloc, n_free, commit_lim, match_ptr;
  logic [PTR_W-1:0] head_idx, tail_idx, rs_idx, rs_age;
  logic [DEPTH-1:0] wr_en, clr_en, trunc_en;
  checkpoint_t      wr_ckpt [DEPTH];
  logic             alloc_ok, do_restore, rs_hit;
  logic [DATA_WIDTH-1:0]       rs_data;
  logic [DEPTH*ROB_WIDTH-1:0]  tags_flat;
  logic [DEPTH*DATA_WIDTH-1:0] data_flat;

  assign count    = head_q - tail_q;
  assign free_cnt = CNT_W'(DEPTH) - count;
  assign head_idx = head_q[PTR_W-1:0];
  assign tail_idx = tail_q[PTR_W-1:0];

  assign o_alloc_ready = (free_cnt >= CNT_W'(ALLOC_W));
  assign o_free_count  = free_cnt;
  assign o_empty       = (count == '0);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      tags_flat[i*ROB_WIDTH +: ROB_WIDTH]   = ckpt_q[i].rob_tag;
      data_flat[i*DATA_WIDTH +: DATA_WIDTH] = ckpt_q[i].data;
    end
  end

  ckpt_age_match #(
    .DATA_WIDTH (DATA_WIDTH),
    .ROB_WIDTH  (ROB_WIDTH),
    .DEPTH      (DEPTH)
  ) u_match (
    .i_valid (valid_q),
    .i_tags  (tags_flat),
    .i_data  (data_flat),
    .i_tail  (tail_idx),
    .i_count (count),
    .i_tag   (i_restore_tag),
    .o_hit   (rs_hit),
    .o_idx   (rs_idx),
    .o_age   (rs_age),
    .o_data  (rs_data)
  );

  assign o_restore_hit  = rs_hit;
  assign o_restore_data = rs_hit ? rs_data : '0;
  assign do_restore     = i_restore && rs_hit;

  // Requesting lanes pack densely into consecutive slots from head.
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot    = '0;
    n_alloc = '0;
    wr_en   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_ckpt[i] = '0;
    end
    for (int l = 0; l < ALLOC_W; l++) begin
      if (i_alloc[l]) begin
        slot                  = head_idx + n_alloc[PTR_W-1:0];
        wr_en[slot]           = 1'b1;
        wr_ckpt[slot].data    = i_alloc_data[l*DATA_WIDTH +: DATA_WIDTH];
        wr_ckpt[slot].rob_tag = i_alloc_tag[l*ROB_WIDTH +: ROB_WIDTH];
        n_alloc               = n_alloc + CNT_W'(1);
      end
    end
  end

  assign alloc_ok = !i_flush && !i_restore && (n_alloc <= free_cnt);

  // During a restore, commit may not reach past the surviving matched entry.
  assign commit_lim = do_restore ? (CNT_W'(rs_age) + CNT_W'(1)) : count;

  always_comb begin
    logic             scan;
    logic [PTR_W-1:0] cidx;
    scan   = 1'b1;
    cidx   = '0;
    n_free = '0;
    clr_en = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      cidx = tail_idx + n_free[PTR_W-1:0];
      if (scan && i_commit[k] && (n_free < commit_lim) && valid_q[cidx] &&
          (ckpt_q[cidx].rob_tag == i_commit_tag[k*ROB_WIDTH +: ROB_WIDTH])) begin
        clr_en[cidx] = 1'b1;
        n_free       = n_free + CNT_W'(1);
      end else begin
        scan = 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      trunc_en[i] = do_restore &&
        (PTR_W'(ckpt_age(ckpt_idx_t'(i), ckpt_idx_t'(tail_idx), ckpt_idx_t'(DEPTH))) > rs_age);
    end
  end

  // Full pointer of the matched slot: same phase as tail unless it sits past the wrap.
  assign match_ptr = {(rs_idx >= tail_idx) ? tail_q[PTR_W] : ~tail_q[PTR_W], rs_idx};

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      valid_d = '0;
    end else begin
      if (do_restore) begin
        head_d = match_ptr + CNT_W'(1);
      end else if (alloc_ok) begin
        head_d = head_q + n_alloc;
      end
      tail_d  = tail_q + n_free;
      valid_d = (valid_q & ~trunc_en & ~clr_en) | (alloc_ok ? wr_en : '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_ok && wr_en[i]) begin
        ckpt_q[i] <= wr_ckpt[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_checkpoint_queue_mw.sv
// Bench for checkpoint_queue_mw: queue-based reference model plus directed literal checks.
`default_nettype none

module tb_checkpoint_queue_mw;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  i_alloc;
  logic [9:0]  i_alloc_tag;
  logic [63:0] i_alloc_data;
  logic        o_alloc_ready;
  logic [3:0]  o_free_count;
  logic [1:0]  i_commit;
  logic [9:0]  i_commit_tag;
  logic        i_restore;
  logic [4:0]  i_restore_tag;
  logic        o_restore_hit;
  logic [31:0] o_restore_data;
  logic        i_flush;
  logic        o_empty;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] data;
  } ent_t;
  ent_t mq[$];

  checkpoint_queue_mw dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_alloc        (i_alloc),
    .i_alloc_tag    (i_alloc_tag),
    .i_alloc_data   (i_alloc_data),
    .o_alloc_ready  (o_alloc_ready),
    .o_free_count   (o_free_count),
    .i_commit       (i_commit),
    .i_commit_tag   (i_commit_tag),
    .i_restore      (i_restore),
    .i_restore_tag  (i_restore_tag),
    .o_restore_hit  (o_restore_hit),
    .o_restore_data (o_restore_data),
    .i_flush        (i_flush),
    .o_empty        (o_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Oldest entry (front of queue) carrying this tag, or -1.
  function automatic int model_find(logic [4:0] tag);
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].tag == tag) return i;
    end
    return -1;
  endfunction

  function automatic void model_step();
    int a, lim, nf, n;
    ent_t e;
    if (i_flush) begin
      mq.delete();
      return;
    end
    a   = model_find(i_restore_tag);
    lim = (i_restore && a >= 0) ? a + 1 : mq.size();
    nf  = 0;
    for (int k = 0; k < 2; k++) begin
      if (!i_commit[k]) break;
      if (nf < lim && mq[nf].tag == i_commit_tag[k*5 +: 5]) nf++;
      else break;
    end
    n = $countones(i_alloc);
    if (i_restore) begin
      if (a >= 0) begin
        while (mq.size() > a + 1) void'(mq.pop_back());
      end
    end else if (n <= 8 - mq.size()) begin
      for (int l = 0; l < 2; l++) begin
        if (i_alloc[l]) begin
          e.tag  = i_alloc_tag[l*5 +: 5];
          e.data = i_alloc_data[l*32 +: 32];
          mq.push_back(e);
        end
      end
    end
    repeat (nf) void'(mq.pop_front());
  endfunction

  always @(posedge clk) begin
    if (!reset_n) mq.delete();
    else model_step();
  end

  always @(negedge clk) begin
    int a;
    if (chk_en) begin
      if (!reset_n) begin
        chk("m_ready", {31'd0, o_alloc_ready}, 32'd1);
        chk("m_free", {28'd0, o_free_count}, 32'd8);
        chk("m_empty", {31'd0, o_empty}, 32'd1);
        chk("m_hit", {31'd0, o_restore_hit}, 32'd0);
        chk("m_data", o_restore_data, 32'd0);
      end else begin
        a = model_find(i_restore_tag);
        chk("m_ready", {31'd0, o_alloc_ready}, {31'd0, (8 - mq.size()) >= 2});
        chk("m_free", {28'd0, o_free_count}, 32'(8 - mq.size()));
        chk("m_empty", {31'd0, o_empty}, {31'd0, mq.size() == 0});
        chk("m_hit", {31'd0, o_restore_hit}, {31'd0, a >= 0});
        chk("m_data", o_restore_data, (a >= 0) ? mq[a].data : 32'd0);
      end
    end
  end

  task automatic idle();
    i_alloc = '0; i_alloc_tag = '0; i_alloc_data = '0;
    i_commit = '0; i_commit_tag = '0;
    i_restore = 1'b0; i_restore_tag = '0; i_flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(logic [1:0] m, logic [4:0] t0, logic [31:0] d0,
                           logic [4:0] t1, logic [31:0] d1);
    i_alloc = m; i_alloc_tag = {t1, t0}; i_alloc_data = {d1, d0};
  endtask

  task automatic set_commit(logic [1:0] m, logic [4:0] t0, logic [4:0] t1);
    i_commit = m; i_commit_tag = {t1, t0};
  endtask

  task automatic do_flush();
    idle(); i_flush = 1'b1; tick(); idle();
  endtask

  task automatic rand_cycle();
    int sz;
    idle();
    sz = mq.size();
    if ($urandom_range(0, 99) < 2) i_flush = 1'b1;
    i_alloc = 2'($urandom_range(0, 3));
    if (sz > 6 && $urandom_range(0, 9) != 0) i_alloc = '0;
    i_alloc_tag  = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
    i_alloc_data = {$urandom, $urandom};
    for (int k = 0; k < 2; k++) begin
      i_commit[k] = ($urandom_range(0, 1) == 1);
      if (k < sz && $urandom_range(0, 3) != 0) i_commit_tag[k*5 +: 5] = mq[k].tag;
      else i_commit_tag[k*5 +: 5] = 5'($urandom_range(0, 15));
    end
    i_restore = ($urandom_range(0, 9) == 0);
    if (sz > 0 && $urandom_range(0, 3) != 0)
      i_restore_tag = mq[$urandom_range(0, sz - 1)].tag;
    else
      i_restore_tag = 5'($urandom_range(0, 15));
    tick();
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;
    #1;
    chk("rst_ready", {31'd0, o_alloc_ready}, 32'd1);
    chk("rst_free", {28'd0, o_free_count}, 32'd8);
    chk("rst_empty", {31'd0, o_empty}, 32'd1);
    chk("rst_hit", {31'd0, o_restore_hit}, 32'd0);
    chk("rst_data", o_restore_data, 32'd0);

    // Two-lane alloc, then restore the younger tag.
    set_alloc(2'b11, 5'd3, 32'hAAAA_0001, 5'd4, 32'hBBBB_0002); tick(); idle();
    #1;
    chk("t1_free", {28'd0, o_free_count}, 32'd6);
    chk("t1_empty", {31'd0, o_empty}, 32'd0);
    i_restore = 1'b1; i_restore_tag = 5'd4; #1;
    chk("t1_hit", {31'd0, o_restore_hit}, 32'd1);
    chk("t1_data", o_restore_data, 32'hBBBB_0002);
    tick(); idle();

    // Fill to full, overflow request is dropped, then one commit.
    set_alloc(2'b11, 5'd5, 32'h5, 5'd6, 32'h6); tick();
    set_alloc(2'b11, 5'd7, 32'h7, 5'd8, 32'h8); tick();
    set_alloc(2'b11, 5'd9, 32'h9, 5'd10, 32'hA); tick(); idle();
    #1;
    chk("full_free", {28'd0, o_free_count}, 32'd0);
    set_alloc(2'b01, 5'd11, 32'hB, 5'd0, 32'h0); #1;
    chk("full_ready", {31'd0, o_alloc_ready}, 32'd0);
    tick(); idle(); #1;
    chk("drop_free", {28'd0, o_free_count}, 32'd0);
    set_commit(2'b01, 5'd3, 5'd0); tick(); idle(); #1;
    chk("commit_free", {28'd0, o_free_count}, 32'd1);

    // Tags 1..6, restore tag 3 truncates younger entries.
    do_flush();
    set_alloc(2'b11, 5'd1, 32'h11, 5'd2, 32'h12); tick();
    set_alloc(2'b11, 5'd3, 32'h13, 5'd4, 32'h14); tick();
    set_alloc(2'b11, 5'd5, 32'h15, 5'd6, 32'h16); tick(); idle();
    i_restore = 1'b1; i_restore_tag = 5'd3; #1;
    chk("tr_hit", {31'd0, o_restore_hit}, 32'd1);
    tick(); idle(); #1;
    chk("tr_free", {28'd0, o_free_count}, 32'd5);
    i_restore_tag = 5'd5; #1;
    chk("tr_gone", {31'd0, o_restore_hit}, 32'd0);

    // Alloc + commit + restore in the same cycle.
    do_flush();
    set_alloc(2'b11, 5'd10, 32'h20, 5'd11, 32'h21); tick();
    set_alloc(2'b11, 5'd12, 32'h22, 5'd13, 32'h23); tick();
    set_alloc(2'b11, 5'd14, 32'h24, 5'd15, 32'h25); tick(); idle();
    set_alloc(2'b11, 5'd16, 32'h26, 5'd17, 32'h27);
    set_commit(2'b01, 5'd10, 5'd0);
    i_restore = 1'b1; i_restore_tag = 5'd12;
    tick(); idle(); #1;
    chk("mix_free", {28'd0, o_free_count}, 32'd6);
    i_restore_tag = 5'd16; #1;
    chk("mix_noalloc", {31'd0, o_restore_hit}, 32'd0);

    // Move tail to 6, then stream single alloc/commit pairs across the wrap.
    do_flush();
    set_alloc(2'b11, 5'd1, 32'h1, 5'd2, 32'h2); tick();
    set_alloc(2'b11, 5'd3, 32'h3, 5'd4, 32'h4); tick();
    set_alloc(2'b11, 5'd5, 32'h5, 5'd6, 32'h6); tick(); idle();
    set_commit(2'b11, 5'd1, 5'd2); tick();
    set_commit(2'b11, 5'd3, 5'd4); tick();
    set_commit(2'b11, 5'd5, 5'd6); tick(); idle();
    for (int i = 0; i < 20; i++) begin
      idle();
      set_alloc(2'b01, 5'(8 + i), 32'(32'h100 + i), 5'd0, 32'd0);
      if (i > 0) set_commit(2'b01, 5'(7 + i), 5'd0);
      tick();
    end
    idle(); #1;
    chk("wrap_free", {28'd0, o_free_count}, 32'd7);
    i_restore = 1'b1; i_restore_tag = 5'd27; #1;
    chk("wrap_hit", {31'd0, o_restore_hit}, 32'd1);
    chk("wrap_data", o_restore_data, 32'h113);
    tick(); idle();

    // Aliased tag at slots 2 and 6 with tail at 1: the older one wins.
    do_flush();
    set_alloc(2'b01, 5'd30, 32'h30, 5'd0, 32'd0); tick(); idle();
    set_commit(2'b01, 5'd30, 5'd0); tick(); idle();
    set_alloc(2'b11, 5'd20, 32'h40, 5'd7, 32'hD2D2_0002); tick();
    set_alloc(2'b11, 5'd21, 32'h41, 5'd22, 32'h42); tick();
    set_alloc(2'b11, 5'd23, 32'h43, 5'd7, 32'hD6D6_0006); tick(); idle();
    i_restore_tag = 5'd7; #1;
    chk("alias_hit", {31'd0, o_restore_hit}, 32'd1);
    chk("alias_data", o_restore_data, 32'hD2D2_0002);

    // Flush wins over a simultaneous restore.
    i_flush = 1'b1; i_restore = 1'b1; tick(); idle(); #1;
    chk("flush_free", {28'd0, o_free_count}, 32'd8);
    chk("flush_empty", {31'd0, o_empty}, 32'd1);

    for (int c = 0; c < 3000; c++) rand_cycle();
    idle();

    // Asynchronous reset between clock edges.
    do_flush();
    set_alloc(2'b11, 5'd1, 32'h51, 5'd2, 32'h52); tick(); idle();
    i_restore_tag = 5'd1;
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, o_alloc_ready}, 32'd1);
    chk("arst_free", {28'd0, o_free_count}, 32'd8);
    chk("arst_empty", {31'd0, o_empty}, 32'd1);
    chk("arst_hit", {31'd0, o_restore_hit}, 32'd0);
    chk("arst_data", o_restore_data, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
